// File: rtl/bs_pack_core.sv
// bs_pack_core: packs variable-length code tokens into fixed-width output
// words, LSB-first (deflate order) or MSB-first, with a final flush word.
module bs_pack_core #(
    parameter int unsigned DATA_WD   = 32,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned LEN_WD    = 6,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        val_i,
    input  logic [LEN_WD-1:0]           len_i,
    input  logic [MAX_LEN-1:0]          dat_i,
    input  logic                        lst_i,
    output logic                        rdy_o,
    output logic                        val_o,
    output logic [DATA_WD-1:0]          dat_o,
    output logic [$clog2(DATA_WD/8):0]  byt_o,
    output logic                        lst_o,
    input  logic                        rdy_i,
    output logic                        done_o
);

    localparam int unsigned ACC_WD = DATA_WD + MAX_LEN;
    localparam int unsigned CNT_WD = $clog2(ACC_WD + 1);
    localparam int unsigned BYT_WD = $clog2(DATA_WD / 8) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ACC_WD-1:0]   acc_q, acc_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                val_q, val_d;
    logic [DATA_WD-1:0]  dat_q, dat_d;
    logic [BYT_WD-1:0]   byt_q, byt_d;
    logic                lst_q, lst_d;
    logic                done_q, done_d;

    logic [LEN_WD-1:0]   len_eff;
    logic [CNT_WD-1:0]   len_cnt;
    logic [CNT_WD-1:0]   msb_pos;
    logic [ACC_WD-1:0]   code_msk;
    logic [ACC_WD-1:0]   app_vec;
    logic [ACC_WD-1:0]   acc_shf;
    logic [DATA_WD-1:0]  head_word;
    logic                cnt_full;
    logic                cnt_over;
    logic                accept;
    logic                consume;

    // Token alignment, oldest-word extraction and word-drain shift.
    always_comb begin
        len_eff   = (len_i > LEN_WD'(MAX_LEN)) ? LEN_WD'(MAX_LEN) : len_i;
        len_cnt   = CNT_WD'(len_eff);
        code_msk  = ACC_WD'(dat_i) & ~({ACC_WD{1'b1}} << len_eff);
        // MSB-first keeps the stream left-aligned: the new code's top bit
        // lands directly below the bits already held.
        msb_pos   = CNT_WD'(ACC_WD) - cnt_q - len_cnt;
        app_vec   = MSB_FIRST ? (code_msk << msb_pos) : (code_msk << cnt_q);
        acc_shf   = MSB_FIRST ? (acc_q << DATA_WD) : (acc_q >> DATA_WD);
        head_word = MSB_FIRST ? acc_q[ACC_WD-1 -: DATA_WD] : acc_q[DATA_WD-1:0];
        cnt_full  = (cnt_q >= CNT_WD'(DATA_WD));
        cnt_over  = (cnt_q >  CNT_WD'(DATA_WD));
        // rdy_q mirrors (RUN && cnt < DATA_WD) for the current cycle.
        accept    = rdy_q && val_i;
        consume   = val_q && rdy_i;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        dat_d   = dat_q;
        byt_d   = byt_q;
        lst_d   = lst_q;

        if (start_i) begin
            state_d = ST_RUN;
            acc_d   = '0;
            cnt_d   = '0;
            val_d   = 1'b0;
            dat_d   = '0;
            byt_d   = '0;
            lst_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_d = acc_q | app_vec;
                        cnt_d = cnt_q + len_cnt;
                        if (lst_i) begin
                            state_d = ST_FLUSH;
                        end
                    end else if (consume) begin
                        acc_d = acc_shf;
                        cnt_d = cnt_q - CNT_WD'(DATA_WD);
                        val_d = 1'b0;
                    end else if (!val_q && cnt_full) begin
                        val_d = 1'b1;
                        dat_d = head_word;
                        byt_d = BYT_WD'(DATA_WD / 8);
                        lst_d = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (consume) begin
                        val_d = 1'b0;
                        if (lst_q) begin
                            state_d = ST_DONE;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            acc_d = acc_shf;
                            cnt_d = cnt_q - CNT_WD'(DATA_WD);
                        end
                    end else if (!val_q) begin
                        val_d = 1'b1;
                        dat_d = head_word;
                        if (cnt_over) begin
                            byt_d = BYT_WD'(DATA_WD / 8);
                            lst_d = 1'b0;
                        end else begin
                            // Bits above cnt are already zero, so the head
                            // word is the zero-padded tail as-is.
                            byt_d = BYT_WD'((cnt_q + CNT_WD'(7)) >> 3);
                            lst_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rdy_d  = (state_d == ST_RUN) && (cnt_d < CNT_WD'(DATA_WD));
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            val_q   <= 1'b0;
            dat_q   <= '0;
            byt_q   <= '0;
            lst_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            val_q   <= val_d;
            dat_q   <= dat_d;
            byt_q   <= byt_d;
            lst_q   <= lst_d;
            done_q  <= done_d;
        end
    end

    assign rdy_o  = rdy_q;
    assign val_o  = val_q;
    assign dat_o  = dat_q;
    assign byt_o  = byt_q;
    assign lst_o  = lst_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_bs_pack_core.sv
// tb_bs_pack_core: directed checks of an LSB-first and an MSB-first packer
// driven by the same token stream.
module tb_bs_pack_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        val_i;
    logic [5:0]  len_i;
    logic [31:0] dat_i;
    logic        lst_i;
    logic        rdy_i;

    logic        rdy0, val0, lst0, done0;
    logic [31:0] dat0;
    logic [2:0]  byt0;
    logic        rdy1, val1, lst1, done1;
    logic [31:0] dat1;
    logic [2:0]  byt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bs_pack_core #(.DATA_WD(32), .MAX_LEN(32), .LEN_WD(6), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .len_i(len_i),
        .dat_i(dat_i), .lst_i(lst_i), .rdy_o(rdy0), .val_o(val0), .dat_o(dat0),
        .byt_o(byt0), .lst_o(lst0), .rdy_i(rdy_i), .done_o(done0)
    );

    bs_pack_core #(.DATA_WD(32), .MAX_LEN(32), .LEN_WD(6), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .len_i(len_i),
        .dat_i(dat_i), .lst_i(lst_i), .rdy_o(rdy1), .val_o(val1), .dat_o(dat1),
        .byt_o(byt1), .lst_o(lst1), .rdy_i(rdy_i), .done_o(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_tok(input int len, input logic [31:0] d, input logic l);
        int n = 0;
        val_i = 1'b1;
        len_i = 6'(len);
        dat_i = d;
        lst_i = l;
        while (!rdy0 && n < 50) begin
            tick();
            n++;
        end
        check("tok_rdy", 32'(rdy0), 32'd1);
        tick();
        val_i = 1'b0;
        lst_i = 1'b0;
    endtask

    task automatic wait_val();
        int n = 0;
        while (!val0 && n < 100) begin
            tick();
            n++;
        end
        check("val_wait", 32'(val0), 32'd1);
    endtask

    task automatic consume();
        rdy_i = 1'b1;
        tick();
        rdy_i = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        val_i   = 1'b0;
        len_i   = '0;
        dat_i   = '0;
        lst_i   = 1'b0;
        rdy_i   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_rdy",  32'(rdy0),  32'd0);
        check("rst_val",  32'(val0),  32'd0);
        check("rst_dat",  dat0,       32'd0);
        check("rst_byt",  32'(byt0),  32'd0);
        check("rst_lst",  32'(lst0),  32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // 3+5 bit stream, both bit orders
        pulse_start();
        send_tok(3, 32'b101, 1'b0);
        send_tok(5, 32'b11001, 1'b1);
        check("a_rdy_flush", 32'(rdy0), 32'd0);
        wait_val();
        check("a_dat_lsb", dat0,      32'h0000_00CD);
        check("a_byt_lsb", 32'(byt0), 32'd1);
        check("a_lst_lsb", 32'(lst0), 32'd1);
        check("a_dat_msb", dat1,      32'hB900_0000);
        check("a_byt_msb", 32'(byt1), 32'd1);
        check("a_lst_msb", 32'(lst1), 32'd1);
        consume();
        check("a_done",     32'(done0), 32'd1);
        check("a_done_msb", 32'(done1), 32'd1);
        tick();
        check("a_done_off", 32'(done0), 32'd0);
        check("a_idle_rdy", 32'(rdy0),  32'd0);

        // Four bytes fill one word, then an empty last token
        pulse_start();
        send_tok(8, 32'h11, 1'b0);
        send_tok(8, 32'h22, 1'b0);
        send_tok(8, 32'h33, 1'b0);
        send_tok(8, 32'h44, 1'b0);
        check("b_rdy_full", 32'(rdy0), 32'd0);
        wait_val();
        check("b_dat_lsb", dat0,      32'h4433_2211);
        check("b_dat_msb", dat1,      32'h1122_3344);
        check("b_byt",     32'(byt0), 32'd4);
        check("b_lst",     32'(lst0), 32'd0);
        check("b_rdy_hold", 32'(rdy0), 32'd0);
        consume();
        send_tok(0, 32'hFFFF_FFFF, 1'b1);
        wait_val();
        check("b_zero_dat", dat0,      32'd0);
        check("b_zero_byt", 32'(byt0), 32'd0);
        check("b_zero_lst", 32'(lst0), 32'd1);
        consume();
        check("b_done", 32'(done0), 32'd1);
        tick();

        // Two 20-bit tokens with a five-cycle downstream stall
        pulse_start();
        send_tok(20, 32'hABCDE, 1'b0);
        send_tok(20, 32'hABCDE, 1'b1);
        wait_val();
        for (int i = 0; i < 5; i++) begin
            check("c_stall_dat", dat0,      32'hCDEA_BCDE);
            check("c_stall_byt", 32'(byt0), 32'd4);
            check("c_stall_lst", 32'(lst0), 32'd0);
            check("c_stall_rdy", 32'(rdy0), 32'd0);
            tick();
        end
        check("c_w0_msb", dat1, 32'hABCD_EABC);
        consume();
        wait_val();
        check("c_w1_dat", dat0,      32'h0000_00AB);
        check("c_w1_byt", 32'(byt0), 32'd1);
        check("c_w1_lst", 32'(lst0), 32'd1);
        check("c_w1_msb", dat1,      32'hDE00_0000);
        consume();
        check("c_done", 32'(done0), 32'd1);
        tick();

        // Reset mid-stream discards the partial word
        pulse_start();
        send_tok(12, 32'hFFF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("d_rst_rdy", 32'(rdy0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("d_rst_val", 32'(val0), 32'd0);
            tick();
        end
        pulse_start();
        send_tok(8, 32'h5A, 1'b1);
        wait_val();
        check("d_new_dat", dat0,      32'h0000_005A);
        check("d_new_byt", 32'(byt0), 32'd1);
        consume();
        tick();

        // Restart mid-stream discards the partial word
        pulse_start();
        send_tok(12, 32'hFFF, 1'b0);
        pulse_start();
        check("e_restart_val", 32'(val0), 32'd0);
        check("e_restart_rdy", 32'(rdy0), 32'd1);
        send_tok(4, 32'h3, 1'b1);
        wait_val();
        check("e_new_dat", dat0,      32'h0000_0003);
        check("e_new_msb", dat1,      32'h3000_0000);
        check("e_new_byt", 32'(byt0), 32'd1);
        consume();
        check("e_done", 32'(done0), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
